// File: rtl/debounce_edge.sv
// debounce_edge: multi-channel synchroniser, stability-counter debouncer and edge detector.
// Each channel is independent. The debounced level o follows the synchronised input only
// after that input has differed from o for STABLE_CYCLES consecutive clocks. rise, fall
// and evt are registered, so they line up with the cycle in which the new o first appears.
module debounce_edge #(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      SYNC_STAGES   = 2,
  parameter int unsigned      STABLE_CYCLES = 4,
  // evt source: 0 = rise, 1 = fall, 2 = both
  parameter int unsigned      EDGE_MODE     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CntW-1:0]  cnt_q  [WIDTH];
  logic [CntW-1:0]  cnt_d  [WIDTH];
  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] evt_q, evt_d;
  logic [WIDTH-1:0] sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw pins, later stages shift.
  always_comb begin
    sync_d[0] = i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Stability counter per channel; any agreement between s and o restarts the count.
  always_comb begin
    o_d = o_q;
    for (int n = 0; n < WIDTH; n++) begin
      cnt_d[n] = '0;
      if (sync_out[n] != o_q[n]) begin
        if (cnt_q[n] == CntMax) begin
          o_d[n] = sync_out[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
  end

  // Edge pulses derived from the next level so they coincide with the registered o change.
  always_comb begin
    rise_d = o_d & ~o_q;
    fall_d = ~o_d & o_q;
    if (EDGE_MODE == 1) begin
      evt_d = fall_d;
    end else if (EDGE_MODE == 2) begin
      evt_d = rise_d | fall_d;
    end else begin
      evt_d = rise_d;
    end
  end

  // State registers; reset aborts any count in progress without producing a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
      o_q    <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
      o_q    <= o_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
    end
  end

  assign o    = o_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign evt  = evt_q;

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Parametrised multi-channel input conditioner. It is the next generation of the team's single-bit `i` → `o` registered block. Each of `WIDTH` asynchronous inputs is synchronised, then debounced with a stability counter. The block produces a clean level plus single-cycle rise, fall and mode-selected event pulses, and sits between raw pins or foreign-clock signals and control logic in the `clk` domain.

## Interface
- `WIDTH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `STABLE_CYCLES`, 4: consecutive cycles a synchronised value must differ from `o` before `o` follows (≥1).
- `EDGE_MODE`, 0: `evt` source. 0 = rise, 1 = fall, 2 = both.
- `RESET_VAL`, 0: per-channel reset level, `WIDTH` bits, applied to the synchroniser chain and `o`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low; deassertion is synchronous to `clk` externally.
- `i` in `WIDTH`: raw asynchronous inputs.
- `o` out `WIDTH`: debounced level.
- `rise` out `WIDTH`: one-cycle pulse when `o[n]` goes 0→1.
- `fall` out `WIDTH`: one-cycle pulse when `o[n]` goes 1→0.
- `evt` out `WIDTH`: `rise`, `fall` or `rise|fall` per `EDGE_MODE`.

## Operation
- Channels are fully independent. There is no shared state.
- Per channel: `s` is the last synchroniser stage, `cnt` is a counter of width clog2(`STABLE_CYCLES`+1), and `o` is the registered output.
- Each rising edge:
  - If `s == o`: `cnt` ← 0.
  - Else if `cnt == STABLE_CYCLES-1`: `o` ← `s` and `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
- `rise`, `fall` and `evt` are registered. They are high exactly in the cycle where the new `o` is first visible, and low otherwise.
- Any return of `s` to `o` before the threshold clears `cnt`. A glitch shorter than `STABLE_CYCLES` synchronised cycles never reaches `o`.
- With `STABLE_CYCLES`=1, `o` follows `s` one edge later (pure synchroniser plus edge detect).
- `cnt` never exceeds `STABLE_CYCLES-1`, so no wrap-around is possible.
- Simultaneous changes on several channels are processed in parallel. Multiple bits of `rise`, `fall` and `evt` may be set in the same cycle.

## Timing
- Reset (`rst_n` low): immediately and asynchronously, sync chain = `RESET_VAL`, `o` = `RESET_VAL`, `cnt` = 0, `rise` = `fall` = `evt` = 0.
- Reset asserted mid-count aborts the count with no pulse. After release, the debounce restarts from `cnt` = 0.
- Latency: for `i[n]` changed before edge E0 and held, `o[n]` changes at edge E0+`SYNC_STAGES`+`STABLE_CYCLES`-1. That is `SYNC_STAGES`+`STABLE_CYCLES` edges counting E0. The pulse is coincident with the `o` change.
- Minimum separation between two pulses on one channel is `STABLE_CYCLES` cycles.
- No input handshake. Outputs are valid every cycle after reset.
- If `i` differs from `RESET_VAL` at reset release, the normal debounce applies and produces an edge pulse after the standard latency.

## Test plan
Configuration: `WIDTH`=4, `SYNC_STAGES`=2, `STABLE_CYCLES`=4 (latency 6 edges) unless stated.
- Reset: `rst_n` low for 10 cycles with `i`=4'hF → `o`=0 and all pulses 0 during reset. Release → `o`=4'hF at the 6th edge, `rise`=4'hF for exactly 1 cycle, `fall`=0.
- Clean step: `i[0]` 0→1 and held → `o[0]`=1 at the 6th edge. `rise[0]` and `evt[0]` (`EDGE_MODE`=0) high for 1 cycle. Later 1→0 → `fall[0]` pulse with `evt[0]` staying 0.
- Glitch: `i[1]` high for 3 cycles, then low → `o[1]` stays 0 and no pulses. Repeat with 4 cycles high → `o[1]` rises, then falls 4 cycles later.
- Bounce: `i[2]` toggles every 2 cycles 5 times, then held 1 → exactly one `rise[2]` pulse, 6 edges after the final transition.
- Async reset mid-count: `i[3]` 0→1, `rst_n` pulsed low 3 cycles later (not clock-aligned) → `o`=0 and pulses 0 immediately. After release, `o[3]`=1 six edges later.
- `EDGE_MODE`=2, `RESET_VAL`=4'hA: `i`=4'hA, then 4'h5 → `rise`=4'h5, `fall`=4'hA and `evt`=4'hF, all in the same single cycle.
